// File: rtl/sseg_display_scheduler_pkg.sv
// Shared encodings for the seven-segment display scheduler: owner codes,
// blank patterns and the digit-to-anode helper.
package sseg_display_scheduler_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_SCORE = 2'd1,
        OWN_KEY   = 2'd2
    } owner_e;

    localparam logic [6:0] SSEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'hF;

    // Active-low one-hot anode for a digit slot; an[0] is the rightmost digit.
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        an_select = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/sseg_display_scheduler_if.sv
// Requester inputs and board pin outputs of the display scheduler.
// master = game logic / PS2 side plus pin observer, slave = the scheduler.
interface sseg_display_scheduler_if;
    logic [15:0] score_val;
    logic        score_valid;
    logic [7:0]  key_code;
    logic        key_strobe;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic [1:0]  owner;
    logic [1:0]  digit_idx;

    modport master (
        output score_val, score_valid, key_code, key_strobe,
        input  an, sseg, owner, digit_idx
    );

    modport slave (
        input  score_val, score_valid, key_code, key_strobe,
        output an, sseg, owner, digit_idx
    );
endinterface

// File: rtl/sseg_display_scheduler_hex_decode.sv
// Hex nibble to active-low seven-segment pattern (bit6=a .. bit0=g); purely combinational.
// Latency: zero cycles; backpressure: none.
module sseg_hex_decode (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = 7'b1111111;
        case (hex_i)
            4'h0: seg_o = 7'b0000001;
            4'h1: seg_o = 7'b1001111;
            4'h2: seg_o = 7'b0010010;
            4'h3: seg_o = 7'b0000110;
            4'h4: seg_o = 7'b1001100;
            4'h5: seg_o = 7'b0100100;
            4'h6: seg_o = 7'b0100000;
            4'h7: seg_o = 7'b0001111;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0000100;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b1100000;
            4'hC: seg_o = 7'b0110001;
            4'hD: seg_o = 7'b1000010;
            4'hE: seg_o = 7'b0110000;
            4'hF: seg_o = 7'b0111000;
        endcase
    end
endmodule

// File: rtl/sseg_display_scheduler.sv
// Arbitrates the 4-digit display between score and key overlay and scans it with a blanking guard.
// Latency: an/sseg one cycle behind the scan state; backpressure: none, requests are sampled every cycle.
module sseg_display_scheduler
    import sseg_display_scheduler_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int HOLD_CYCLES  = 100000000
) (
    input  logic clk,
    input  logic reset,
    sseg_display_scheduler_if.slave disp
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SLOT_SHOW = SW'(BLANK_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    owner_e      owner_q, owner_d;
    logic [1:0]  digit_idx_q, digit_idx_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]  key_code_q, key_code_d;
    logic [15:0] score_snap_q, score_snap_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  sseg_q, sseg_d;
    logic        frame_wrap;
    logic [3:0]  score_nib;
    logic [3:0]  nibble;
    logic [6:0]  seg_dec;

    always_comb begin
        owner_d = owner_q;
        case (owner_q)
            OWN_IDLE: begin
                if (disp.key_strobe)       owner_d = OWN_KEY;
                else if (disp.score_valid) owner_d = OWN_SCORE;
            end
            OWN_SCORE: begin
                if (disp.key_strobe)        owner_d = OWN_KEY;
                else if (!disp.score_valid) owner_d = OWN_IDLE;
            end
            OWN_KEY: begin
                if (!disp.key_strobe && hold_q == HOLD_LAST)
                    owner_d = disp.score_valid ? OWN_SCORE : OWN_IDLE;
            end
            default: owner_d = OWN_IDLE;
        endcase
    end

    always_comb begin
        slot_d       = slot_q;
        digit_idx_d  = digit_idx_q;
        hold_d       = '0;
        key_code_d   = key_code_q;
        score_snap_d = score_snap_q;
        frame_wrap   = (slot_q == SLOT_LAST) && (digit_idx_q == 2'd3);

        // Any owner change restarts at digit 0 so the new owner starts on a blank guard.
        if (owner_d != owner_q) begin
            slot_d      = '0;
            digit_idx_d = '0;
        end else if (slot_q == SLOT_LAST) begin
            slot_d      = '0;
            digit_idx_d = digit_idx_q + 2'd1;
        end else begin
            slot_d = slot_q + 1'b1;
        end

        if (owner_q == OWN_KEY && owner_d == OWN_KEY && !disp.key_strobe && hold_q != HOLD_LAST)
            hold_d = hold_q + 1'b1;

        if (disp.key_strobe)
            key_code_d = disp.key_code;

        // Snapshot only at frame boundaries so a score update never tears a frame.
        if ((owner_d == OWN_SCORE && owner_q != OWN_SCORE) || (owner_d == owner_q && frame_wrap))
            score_snap_d = disp.score_val;
    end

    always_comb begin
        score_nib = score_snap_q[3:0];
        case (digit_idx_q)
            2'd0: score_nib = score_snap_q[3:0];
            2'd1: score_nib = score_snap_q[7:4];
            2'd2: score_nib = score_snap_q[11:8];
            2'd3: score_nib = score_snap_q[15:12];
            default: score_nib = score_snap_q[3:0];
        endcase
        nibble = score_nib;
        if (owner_q == OWN_KEY)
            nibble = digit_idx_q[0] ? key_code_q[7:4] : key_code_q[3:0];
    end

    sseg_hex_decode u_hex_decode (
        .hex_i (nibble),
        .seg_o (seg_dec)
    );

    always_comb begin
        an_d   = AN_OFF;
        sseg_d = SSEG_BLANK;
        if (slot_q >= SLOT_SHOW &&
            (owner_q == OWN_SCORE || (owner_q == OWN_KEY && !digit_idx_q[1]))) begin
            an_d   = an_select(digit_idx_q);
            sseg_d = seg_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= OWN_IDLE;
            digit_idx_q  <= '0;
            slot_q       <= '0;
            hold_q       <= '0;
            key_code_q   <= '0;
            score_snap_q <= '0;
            an_q         <= AN_OFF;
            sseg_q       <= SSEG_BLANK;
        end else begin
            owner_q      <= owner_d;
            digit_idx_q  <= digit_idx_d;
            slot_q       <= slot_d;
            hold_q       <= hold_d;
            key_code_q   <= key_code_d;
            score_snap_q <= score_snap_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
        end
    end

    assign disp.an        = an_q;
    assign disp.sseg      = sseg_q;
    assign disp.owner     = owner_q;
    assign disp.digit_idx = digit_idx_q;

endmodule

// File: doc/sseg_display_scheduler.md
Name: sseg_display_scheduler

Overview:
- Owns the 4-digit seven-segment display and shares it between two requesters: a 4-digit score source and a 2-digit keyboard-code overlay.
- Key overlay preempts score for a fixed hold window, then the display returns to the score or to blank.
- Scans the digits with registered anodes and segments, and inserts a blanking guard at each digit switch.
- Sits between game logic / PS2 receiver and the board anode/segment pins.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot; must be >= BLANK_CYCLES+1.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off (anti-ghosting).
- HOLD_CYCLES, 100000000: key overlay duration in clk cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- score_val  in  16  four hex digits; [3:0] shown rightmost.
- score_valid  in  1  score source requests the display.
- key_code  in  8  key scan code.
- key_strobe  in  1  one-cycle pulse; latches key_code and requests the overlay.
- an  out  4  active-low anodes; an[0] is the rightmost digit.
- sseg  out  7  active-low segments; bit6=a ... bit0=g.
- owner  out  2  current owner: 0=IDLE, 1=SCORE, 2=KEY.
- digit_idx  out  2  digit slot currently being scanned.

Behaviour:
- Reset values: an=4'b1111, sseg=7'b1111111, owner=0, digit_idx=0. All counters are 0 and the latched code/score are 0. Reset takes priority over every other input, including a key_strobe in the same cycle.
- Owner FSM states: IDLE, SCORE, KEY.
  - IDLE -> KEY on key_strobe.
  - IDLE -> SCORE on score_valid (when no strobe).
  - SCORE -> KEY on key_strobe.
  - SCORE -> IDLE when score_valid=0 (checked every cycle).
  - KEY -> KEY on key_strobe: relatch the code and reload the hold counter to 0.
  - When the hold counter reaches HOLD_CYCLES-1 with no strobe: KEY -> SCORE if score_valid, else KEY -> IDLE.
  - A strobe in the same cycle as hold expiry keeps KEY with a reloaded hold.
- Every owner change restarts the scan: digit_idx=0, slot counter=0, which forces a blanking phase.
- Scan: the slot counter runs 0..SCAN_DIV-1. At wrap, digit_idx increments mod 4. In IDLE, digit_idx and the counter still run.
- Blanking: while slot counter < BLANK_CYCLES, an=4'b1111 and sseg=7'b1111111.
- Display phase, SCORE: drive an = one-hot-low of digit_idx; sseg = decode(score_snap nibble digit_idx).
  - score_snap is loaded from score_val on entry to SCORE and at every digit_idx 3->0 wrap, so no tearing mid-frame.
- Display phase, KEY:
  - Digits 0/1 show key_code[3:0] / key_code[7:4].
  - Digits 2/3 are blanked: an stays 4'b1111 and sseg=7'h7F.
- IDLE: an=4'b1111 and sseg=7'h7F at all times.
- Outputs an and sseg are registered, one cycle after the counter/state that selects them. owner and digit_idx are the state registers themselves.
- Decode table (hex -> sseg):
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
- Counter widths: $clog2 of each parameter, and no wrap beyond the stated terminal values. The hold counter saturates (it is cleared on leaving KEY).

Decomposition:
- Shared package holds:
  - the owner encoding constants (OWN_IDLE=0, OWN_SCORE=1, OWN_KEY=2);
  - SSEG_BLANK=7'h7F;
  - AN_OFF=4'hF.
- One sub-module, sseg_hex_decode: combinational 4-bit -> 7-bit active-low decoder, instantiated once on the muxed nibble.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2, HOLD_CYCLES=40):
- Reset with score_valid=1 and key_strobe=1 asserted together -> during and one cycle after reset: an=1111, sseg=1111111, owner=0. Next cycle owner=2 only if the strobe persists.
- score_val=16'h12AF, score_valid=1 -> owner=1. Per slot: 2 cycles an=1111, then 6 cycles of:
  - an=1110, sseg=0111000 (F)
  - an=1101, sseg=0001000 (A)
  - an=1011, sseg=0010010 (2)
  - an=0111, sseg=1001111 (1)
- In SCORE, pulse key_strobe with key_code=8'h1C -> owner=2 next cycle and digit_idx=0. Digits 0/1 show 0110001/1001111; digits 2/3 keep an=1111. After 40 cycles owner returns to 1.
- Second strobe (code 8'h3B) at hold cycle 30 -> owner stays 2, new code displayed, and return to SCORE happens 40 cycles after the second strobe. A strobe exactly at expiry also extends.
- Deassert score_valid mid-frame in SCORE -> owner=0 next cycle and outputs blank. Change score_val mid-frame -> the new value appears only after the digit 3->0 wrap.
- Assert reset mid-KEY hold -> all outputs return to reset values next cycle; after release with score_valid=1, SCORE resumes from digit 0 with blanking.
